// File: rtl/store_tx_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : store_tx_buffer_if
// Brief    : Store-side bus between the memory stage and store_tx_buffer,
//            carrying the store strobe/address/data and the FIFO status.
// Revision : 1.0 - initial release
// ============================================================================
interface store_tx_buffer_if #(
    parameter int DEPTH_LOG2 = 4
) ();
    logic                  wr_en;
    logic [31:0]           wr_addr;
    logic [31:0]           wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   level;
    logic [7:0]            drop_cnt;

    modport master (
        output wr_en, wr_addr, wr_data,
        input  full, empty, level, drop_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        output full, empty, level, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/store_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_tx_buffer
// Brief    : Captures byte stores to one MMIO address into a byte FIFO and
//            serializes them on txd as 8N1 frames. Defining the macro
//            STORE_TX_PARITY_EN adds an even-parity bit (8E1 frames).
// Revision : 1.0 - initial release
// ============================================================================
module store_tx_buffer #(
    parameter int          CLKS_PER_BIT = 868,
    parameter int          DEPTH_LOG2   = 4,
    parameter logic [31:0] MMIO_ADDR    = 32'h0000_1000
) (
    input  logic             clk,
    input  logic             reset,
    store_tx_buffer_if.slave bus,
    output logic             txd,
    output logic             tx_busy
);
    localparam int                    c_DEPTH    = 1 << DEPTH_LOG2;
    localparam int                    c_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0]    c_RELOAD   = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0]    c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [DEPTH_LOG2:0]   c_LVL_FULL = (DEPTH_LOG2 + 1)'(c_DEPTH);
    localparam logic [DEPTH_LOG2:0]   c_LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef STORE_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    logic [7:0]            r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic [7:0]            r_drop_cnt;

    state_t                r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [2:0]            r_bit_idx;
    logic [7:0]            r_shift;
    logic                  r_txd;
    logic                  r_busy;
`ifdef STORE_TX_PARITY_EN
    logic                  r_parity;
`endif

    logic       w_full;
    logic       w_empty;
    logic       w_hit;
    logic       w_push;
    logic       w_drop;
    logic       w_pop;
    logic       w_bit_done;
    logic [7:0] w_head;
    logic       w_unused_data;

    // Status comes from the registered level only: no write-through bypass.
    assign w_full        = (r_level == c_LVL_FULL);
    assign w_empty       = (r_level == '0);
    assign w_hit         = bus.wr_en && (bus.wr_addr == MMIO_ADDR);
    assign w_push        = w_hit && !w_full;
    assign w_drop        = w_hit && w_full;
    assign w_bit_done    = (r_cnt == '0);
    assign w_head        = r_mem[r_rd_ptr];
    assign w_pop         = !w_empty &&
                           ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_done));
    assign w_unused_data = ^bus.wr_data[31:8];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.wr_data[7:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
            if (w_drop && (r_drop_cnt != 8'hFF)) begin
                r_drop_cnt <= r_drop_cnt + 8'd1;
            end
        end
    end

    // A pop always coincides with loading the next frame, from IDLE or
    // straight out of STOP for gap-free back-to-back frames.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
`ifdef STORE_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else if (w_pop) begin
            r_state  <= S_START;
            r_shift  <= w_head;
            r_cnt    <= c_RELOAD;
            r_txd    <= 1'b0;
            r_busy   <= 1'b1;
`ifdef STORE_TX_PARITY_EN
            r_parity <= ^w_head;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_txd  <= 1'b1;
                    r_busy <= 1'b0;
                end
                S_START: begin
                    if (w_bit_done) begin
                        r_cnt     <= c_RELOAD;
                        r_bit_idx <= '0;
                        r_txd     <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_cnt <= c_RELOAD;
                        if (r_bit_idx == 3'd7) begin
`ifdef STORE_TX_PARITY_EN
                            r_txd   <= r_parity;
                            r_state <= S_PARITY;
`else
                            r_txd   <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_txd     <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
`ifdef STORE_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_done) begin
                        r_cnt   <= c_RELOAD;
                        r_txd   <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_done) begin
                        r_state <= S_IDLE;
                        r_txd   <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.full     = w_full;
    assign bus.empty    = w_empty;
    assign bus.level    = r_level;
    assign bus.drop_cnt = r_drop_cnt;
    assign txd          = r_txd;
    assign tx_busy      = r_busy;

endmodule
`default_nettype wire
